// File: rtl/int8_mul_sched_if.sv
// Bundle of the requester, multiplier and result signals around int8_mul_sched.
//   slave  : the scheduler side (takes requests and products, drives grants,
//            multiplier operands and tagged results).
//   master : the environment side (requesters, multiplier, result consumer).
// Signals:
//   req_valid/req_ready/req_last [1:0] : per-requester beat handshake
//   req_wt0/1, req_act0/1 [7:0]        : signed weight and activation per requester
//   mul_ena, mul_enb, mul_a, mul_b     : shared multiplier operand strobes/data
//   mul_p [15:0]                       : multiplier product, LAT cycles after issue
//   res_valid/data/id/idx/last, ovf    : tagged result stream and overflow pulse
interface int8_mul_sched_if #(
  parameter int CNT_W = 8
) ();
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req_wt0;
  logic [7:0]       req_wt1;
  logic [7:0]       req_act0;
  logic [7:0]       req_act1;
  logic [1:0]       req_last;
  logic             mul_ena;
  logic             mul_enb;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_p;
  logic             res_valid;
  logic [15:0]      res_data;
  logic             res_id;
  logic [CNT_W-1:0] res_idx;
  logic             res_last;
  logic             ovf;

  modport slave (
    input  req_valid, req_wt0, req_wt1, req_act0, req_act1, req_last, mul_p,
    output req_ready, mul_ena, mul_enb, mul_a, mul_b,
           res_valid, res_data, res_id, res_idx, res_last, ovf
  );

  modport master (
    output req_valid, req_wt0, req_wt1, req_act0, req_act1, req_last, mul_p,
    input  req_ready, mul_ena, mul_enb, mul_a, mul_b,
           res_valid, res_data, res_id, res_idx, res_last, ovf
  );
endinterface

// File: rtl/int8_mul_sched.sv
// Round-robin scheduler sharing one pipelined int8 multiplier between two
// requesters. A granted requester streams a packet of activations; the weight
// is loaded into the multiplier on the packet's first beat only. Each issued
// beat carries a {valid, id, idx, last} tag through a LAT-deep pipeline so the
// tag lines up with the product coming back on mul_p.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : int8_mul_sched_if slave modport (requests, multiplier, results)
module int8_mul_sched #(
  parameter int LAT       = 2,
  parameter int MAX_BEATS = 128,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  int8_mul_sched_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  typedef struct packed {
    logic             valid;
    logic             id;
    logic [CNT_W-1:0] idx;
    logic             last;
  } tag_t;

  state_t           state_q, state_nxt;
  logic             rr_last_q, rr_last_nxt;   // requester granted most recently
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_nxt;
  tag_t             tag_q [LAT];
  tag_t             tag_in;

  logic             sel;                      // requester owning the current grant
  logic [1:0]       ready;
  logic             ena, enb, ovf, at_max, end_pkt;
  logic [7:0]       a, b;

  assign sel    = (state_q == GRANT1);
  assign at_max = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state_q;
    rr_last_nxt  = rr_last_q;
    beat_cnt_nxt = beat_cnt_q;
    ready        = 2'b00;
    ena          = 1'b0;
    enb          = 1'b0;
    a            = 8'h00;
    b            = 8'h00;
    ovf          = 1'b0;
    end_pkt      = 1'b0;
    tag_in       = '0;

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time gets the grant.
        if (bus.req_valid[0] && (!bus.req_valid[1] || rr_last_q)) begin
          state_nxt   = GRANT0;
          rr_last_nxt = 1'b0;
        end else if (bus.req_valid[1]) begin
          state_nxt   = GRANT1;
          rr_last_nxt = 1'b1;
        end
      end

      GRANT0, GRANT1: begin
        ready[sel] = 1'b1;
        // A valid gap simply holds the grant without issuing.
        if (bus.req_valid[sel]) begin
          ena = 1'b1;
          a   = sel ? bus.req_act1 : bus.req_act0;
          if (beat_cnt_q == '0) begin
            enb = 1'b1;
            b   = sel ? bus.req_wt1 : bus.req_wt0;
          end
          // A real last on the forced beat still counts as one end, with ovf.
          end_pkt = bus.req_last[sel] | at_max;
          ovf     = at_max;
          tag_in  = '{valid: 1'b1, id: sel, idx: beat_cnt_q, last: end_pkt};
          if (end_pkt) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt_q + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= '0;
      // NOTE: the tag pipeline is small and its valid bits gate res_valid,
      // so it is cleared on reset to drop in-flight results.
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_nxt;
      rr_last_q  <= rr_last_nxt;
      beat_cnt_q <= beat_cnt_nxt;
      tag_q[0]   <= tag_in;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign bus.req_ready = ready;
  assign bus.mul_ena   = ena;
  assign bus.mul_enb   = enb;
  assign bus.mul_a     = a;
  assign bus.mul_b     = b;
  assign bus.ovf       = ovf;
  assign bus.res_valid = tag_q[LAT-1].valid;
  assign bus.res_id    = tag_q[LAT-1].id;
  assign bus.res_idx   = tag_q[LAT-1].idx;
  assign bus.res_last  = tag_q[LAT-1].last;
  assign bus.res_data  = bus.mul_p;

endmodule

// File: doc/int8_mul_sched.md
# int8_mul_sched

Round-robin scheduler that shares one `CnnInt8Mul` multiplier between two requesters streaming int8 activation packets against a per-packet int8 weight. It grants the multiplier one packet at a time and loads the packet weight on the first beat. It then streams activations and re-aligns the multiplier's pipelined products with requester ID, beat index and last flag. It sits between the CNN operand fetch units and the shared multiplier.

## Interface
Parameters:
- `LAT`, 2: multiplier latency in cycles, from the cycle a beat is issued on `mul_a` to the cycle its product appears on `mul_p`.
- `MAX_BEATS`, 128: maximum beats per packet before forced termination.
- `CNT_W`, 8: beat counter / index width; requires 2^CNT_W >= MAX_BEATS.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid[1:0]` in 2: per-requester beat valid.
- `req_ready[1:0]` out 2: per-requester beat accept.
- `req_wt0`, `req_wt1` in 8: signed weight; sampled only on a packet's first beat.
- `req_act0`, `req_act1` in 8: signed activation.
- `req_last[1:0]` in 2: marks the final beat of a packet.
- `mul_ena` out 1: multiplier `EnA`; high only on an issue cycle.
- `mul_enb` out 1: multiplier `EnB`; high only on a packet's first issued beat.
- `mul_a` out 8: signed activation to the multiplier.
- `mul_b` out 8: signed weight to the multiplier.
- `mul_p` in 16: signed product from the multiplier.
- `res_valid` out 1: result valid.
- `res_data` out 16: signed product; equals `mul_p` in the same cycle.
- `res_id` out 1: requester that owns the result.
- `res_idx` out CNT_W: beat index within the packet, starting at 0.
- `res_last` out 1: result of the packet's final beat, whether from `req_last` or forced.
- `ovf` out 1: one-cycle pulse when a packet is force-terminated at `MAX_BEATS`.

## Operation
- States:
  - `IDLE`: arbitrate.
  - `GRANT0`: serve requester 0.
  - `GRANT1`: serve requester 1.
- Arbitration in `IDLE`:
  - One requester with `req_valid` high: grant it.
  - Both high: grant the requester that is not `rr_last`.
  - The winner is written to `rr_last`. The next state is `GRANTn`.
  - No request: stay in `IDLE`.
- `req_ready[n]` is 1 exactly when the state is `GRANTn`; it is decoded from state (Moore).
- Handshake is `req_valid[n] & req_ready[n]`. Each handshake is one issue:
  - `mul_ena`=1 and `mul_a`=`req_actn`.
  - If `beat_cnt`==0: also `mul_enb`=1 and `mul_b`=`req_wtn`.
  - `beat_cnt` increments on each issue.
- Valid gaps inside a packet: the grant is held, with no issue that cycle.
- Packet end: an issue with `req_last[n]`=1, or an issue with `beat_cnt`==`MAX_BEATS`-1.
  - Next state is `IDLE` and `beat_cnt` clears.
  - The forced case pulses `ovf` on the issue cycle.
  - Remaining beats of a forced packet are treated as a new packet: weight resampled, index restarting at 0.
- Non-issue cycles: `mul_a`, `mul_b`, `mul_ena`, `mul_enb` all drive 0.
- Tag pipeline: a LAT-deep shift register carries {valid, id, idx, last} for each issue. Its output drives `res_valid`, `res_id`, `res_idx` and `res_last`. `res_data` = `mul_p` (pass-through).
- Results are never back-pressured. The consumer must accept every cycle.

## Timing
- Reset values:
  - State `IDLE`, `rr_last`=1 (requester 0 wins the first tie), `beat_cnt`=0, tag pipeline cleared.
  - All outputs are 0.
- Grant: request seen in `IDLE` at cycle t, `req_ready` high at t+1, first possible issue at t+1.
- Packet overhead: after a last beat at cycle t, `IDLE` at t+1 and the next grant at t+2. This gives exactly one bubble between packets.
- Result latency: a beat issued at cycle t has `res_valid` at t+LAT, aligned with `mul_p`.
- Reset mid-packet: the packet is abandoned and in-flight tags are dropped. `res_valid` is 0 from the cycle after reset. `mul_p` is ignored until new issues arrive.
- Simultaneous: a new `req_valid` from the non-owner during `GRANTn` is held until `IDLE`. A `req_last` together with a forced end counts once, with `ovf`=1.

## Test plan
- Single packet, LAT=2:
  - Stimulus: requester 0, wt=-128, acts -128, 127, 5 (last on 5), issued at t1..t3.
  - Required: `mul_enb` only at t1; results 0x4000, 0xC080, 0xFD80 at t3..t5 with idx 0, 1, 2, `res_id`=0, `res_last` only on 0xFD80.
- Tie after reset:
  - Stimulus: both requesters continuously valid with 2-beat packets.
  - Required: grant order 0, 1, 0, 1; exactly one `IDLE` bubble between packets.
- Valid gaps:
  - Stimulus: requester 1 drops `req_valid` for 3 cycles mid-packet.
  - Required: `req_ready[1]` stays 1, `mul_ena`=0 during the gap, indices contiguous, requester 0 not granted.
- Forced end:
  - Stimulus: MAX_BEATS=4, a 6-beat packet with no last.
  - Required: `ovf` pulses on beat 3; `res_last` on idx 3; remaining 2 beats form a new packet with idx 0, 1 and `mul_enb` on its first beat.
- Reset mid-packet:
  - Stimulus: `rst` asserted one cycle after the 2nd issue.
  - Required: no `res_valid` afterwards until new issues; all outputs 0; next tie won by requester 0.
